apb_master: RTL and testbench
=============================

# apb_master

Single-clock APB requester that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers and returns a one-cycle response pulse. Sits directly upstream of `apb_slave`, driving its PADDR/PWRITE/PSEL/PENABLE/PWDATA and consuming PRDATA/PREADY. Adds a wait-state timeout so a hung peripheral cannot stall the requester.

## Interface
Parameters:
- ADDR_W, 32, width of PADDR and cmd_addr
- DATA_W, 32, width of PWDATA/PRDATA and command/response data
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts a command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data, ignored for reads
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  1 = transfer aborted by timeout; valid with rsp_valid
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready / wait-state control

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- cmd_ready = (state == IDLE) && !rst (combinational). Command accepted on an edge where cmd_valid && cmd_ready.
- IDLE: PSEL=0, PENABLE=0. On accept, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA; next state SETUP.
- SETUP: PSEL=1, PENABLE=0; unconditionally -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA held stable from SETUP through the end of ACCESS.
  - PREADY=1 on an edge: complete; next cycle rsp_valid=1, rsp_err=0, rsp_rdata = PRDATA sampled on that edge if read, else 0; -> IDLE.
  - PREADY=0: stay in ACCESS, increment wait counter (width clog2(TIMEOUT+1), cleared on SETUP entry).
  - TIMEOUT>0 and the TIMEOUT-th consecutive PREADY=0 ACCESS edge: abort; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; -> IDLE.
  - PREADY=1 on the same edge the limit would be hit: normal completion wins.
- After completion PADDR/PWRITE/PWDATA retain last values (no toggling in IDLE).
- rsp_valid is high for exactly one cycle per accepted command; rsp_rdata/rsp_err hold until next response.
- Exactly one transfer outstanding; cmd_valid while busy is held off (cmd_ready=0), never dropped or reordered.

## Timing
- Reset (rst=1 at an edge): state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; cmd_ready=0 while rst is high.
- Reset mid-transfer: PSEL/PENABLE low the cycle after the reset edge; no rsp_valid for the killed transfer.
- Zero-wait transfer: accept edge at end of cycle 0; SETUP in cycle 1; ACCESS in cycle 2; rsp_valid and cmd_ready high in cycle 3. Throughput: 1 transfer per 3 cycles.
- N wait states add N ACCESS cycles. With a timeout, rsp_valid with rsp_err=1 comes TIMEOUT cycles after ACCESS entry.
- A new command is accepted in the same cycle rsp_valid is high.

## Test plan
- Write 0xDEADBEEF to 0x10 into `apb_slave`: PSEL=1/PENABLE=0 in cycle 1, PENABLE=1 in cycle 2, rsp_valid=1 with rsp_err=0 and rsp_rdata=0 in cycle 3; slave mem = 0xDEADBEEF.
- Read 0x10 afterwards: rsp_rdata=0xDEADBEEF, rsp_err=0, PWRITE=0 during SETUP/ACCESS.
- Model slave holding PREADY low 3 ACCESS cycles, PRDATA=0x12345678: ACCESS lasts 4 cycles with PADDR/PWRITE/PWDATA stable; rsp_rdata=0x12345678, rsp_err=0.
- TIMEOUT=4, PREADY stuck low: exactly 4 ACCESS cycles; then rsp_valid=1, rsp_err=1, rsp_rdata=0; PSEL=0 and cmd_ready=1 the same cycle. Also PREADY=1 on the 4th edge: normal completion, rsp_err=0.
- Assert rst for one edge during ACCESS: PSEL=PENABLE=0 next cycle, no rsp_valid, all outputs at reset values; cmd_ready=1 once rst is low.
- cmd_valid held high with two queued commands (write 0xA5 to 0x4, then read 0x4): second accepted exactly in the cycle of the first rsp_valid; responses in order; read returns 0xA5.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into an APB SETUP/ACCESS transfer
// and returns a one-cycle response pulse. A wait-state timeout aborts hung transfers.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the edge that would be the TIMEOUT-th stalled edge.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic accept;
  logic done;
  logic abort;

  always_comb begin
    accept = cmd_valid && cmd_ready;
    done   = (state_q == ACCESS) && PREADY;
    // Completion wins when PREADY rises on the same edge the limit is reached.
    abort  = TIMEOUT_EN && (state_q == ACCESS) && !PREADY && (wait_cnt_q == LAST_WAIT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state_q == IDLE) && !rst;
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    PADDR     = paddr_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= done || abort;
      if (accept) begin
        paddr_q  <= cmd_addr;
        pwrite_q <= cmd_write;
        pwdata_q <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
        rsp_err_q   <= 1'b0;
      end else if (abort) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB slave with programmable wait states,
// directed scenarios followed by randomized transfers checked against a model.
module tb_apb_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  // Behavioural slave: holds PREADY low for wait_n ACCESS cycles, cleared by rst.
  int          wait_n  = 0;
  int          acc_cnt = 0;
  logic [31:0] slv_mem [0:63];

  assign PREADY = PSEL && PENABLE && (acc_cnt >= wait_n);
  assign PRDATA = slv_mem[PADDR[7:2]];

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (rst) begin
      for (int i = 0; i < 64; i++) slv_mem[i] <= '0;
    end else if (PSEL && PENABLE && PREADY && PWRITE) begin
      slv_mem[PADDR[7:2]] <= PWDATA;
    end
  end

  // Reference: what the slave's storage should contain after each completed transfer.
  logic [31:0] model_mem [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, {31'd0, PSEL}, 32'd0);
    check({tag, "_penable"}, {31'd0, PENABLE}, 32'd0);
    check({tag, "_paddr"}, PADDR, 32'd0);
    check({tag, "_pwrite"}, {31'd0, PWRITE}, 32'd0);
    check({tag, "_pwdata"}, PWDATA, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  // One complete transfer, called at a negedge while the DUT is idle.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n_acc;
    int          guard;
    exp_err = (waits >= TO);
    n_acc   = exp_err ? TO : waits + 1;
    exp_rd  = (exp_err || w) ? 32'd0 : model_mem[a[7:2]];
    if (!exp_err && w) model_mem[a[7:2]] = d;
    wait_n    = waits;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("setup_psel", {31'd0, PSEL}, 32'd1);
    check("setup_penable", {31'd0, PENABLE}, 32'd0);
    check("setup_paddr", PADDR, a);
    check("setup_pwrite", {31'd0, PWRITE}, {31'd0, w});
    check("setup_pwdata", PWDATA, d);
    check("setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      check("access_psel", {31'd0, PSEL}, 32'd1);
      check("access_penable", {31'd0, PENABLE}, 32'd1);
      check("access_paddr", PADDR, a);
      check("access_pwrite", {31'd0, PWRITE}, {31'd0, w});
      check("access_pwdata", PWDATA, d);
      check("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_psel", {31'd0, PSEL}, 32'd0);
    check("rsp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rsp_paddr_hold", PADDR, a);
    $display("txn %s addr=%08h wdata=%08h waits=%0d -> rdata=%08h err=%0d",
             w ? "WR" : "RD", a, d, waits, rsp_rdata, rsp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // Directed transfers
    run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 0);
    run_cmd(1'b1, 32'h20, 32'h12345678, 0);
    run_cmd(1'b0, 32'h20, 32'hCAFEF00D, 3);
    run_cmd(1'b0, 32'h10, 32'h0, 100);
    run_cmd(1'b1, 32'h24, 32'h55AA55AA, 100);
    run_cmd(1'b0, 32'h24, 32'h0, 2);

    // Two commands queued with cmd_valid held high
    wait_n    = 0;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4;
    cmd_wdata = 32'hA5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_write = 1'b0;
    cmd_wdata = 32'h0;
    check("b2b_busy_ready", {31'd0, cmd_ready}, 32'd0);
    check("b2b_first_pwrite", {31'd0, PWRITE}, 32'd1);
    @(negedge clk);
    check("b2b_busy_ready2", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    model_mem[1] = 32'hA5;
    check("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rsp1_err", {31'd0, rsp_err}, 32'd0);
    check("b2b_rsp1_ready", {31'd0, cmd_ready}, 32'd1);
    $display("txn WR addr=00000004 wdata=000000a5 (queued) -> err=%0d", rsp_err);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_second_setup", {31'd0, PSEL & ~PENABLE}, 32'd1);
    check("b2b_second_pwrite", {31'd0, PWRITE}, 32'd0);
    check("b2b_second_rsp_low", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("b2b_second_access", {31'd0, PENABLE}, 32'd1);
    @(negedge clk);
    check("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rsp2_rdata", rsp_rdata, model_mem[1]);
    $display("txn RD addr=00000004 (queued) -> rdata=%08h err=%0d", rsp_rdata, rsp_err);

    // Reset during ACCESS kills the transfer silently
    wait_n    = 100;
    cmd_write = 1'b1;
    cmd_addr  = 32'h30;
    cmd_wdata = 32'h11223344;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_access", {31'd0, PENABLE}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    check_reset_outputs("midrst");
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", {31'd0, cmd_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    $display("txn reset during ACCESS -> transfer dropped");

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      int          wt;
      w  = 1'($urandom_range(0, 1));
      a  = {24'd0, 6'($urandom_range(0, 15)), 2'b00};
      d  = $urandom;
      wt = $urandom_range(0, 6);
      run_cmd(w, a, d, wt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
